// File: rtl/flipflop_d_pkg.sv
// Shared constants for the master-slave D flip-flop slice.
package flipflop_d_pkg;
  localparam int DEF_WIDTH = 1;
endpackage

// File: rtl/flipflop_d_if.sv
// Data bundle of the flip-flop: the producer drives d, the flip-flop returns q/qbar.
interface flipflop_d_if
  import flipflop_d_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (output d, input q, input qbar);
  modport slave  (input d, output q, output qbar);
endinterface

// File: rtl/d_latch.sv
// Gated NAND D latch with dual-rail data input and active-low clear.
// Transparent while en=1; clr_n=0 forces q=0/qbar=1 regardless of en.
module d_latch (
  input  wire en,
  input  wire clr_n,
  input  wire d,
  input  wire dn,
  output wire q,
  output wire qbar
);
  wire s_n, r_n;

  // clr_n holds the set side inactive and forces qbar high, so q settles to 0.
  nand g_s  (s_n,  d,   en, clr_n);
  nand g_r  (r_n,  dn,  en);
  nand g_q  (q,    s_n, qbar);
  nand g_qb (qbar, r_n, q, clr_n);
endmodule

// File: rtl/flipflop_d.sv
// Structural rising-edge D flip-flop: per bit a master latch open on clk=0
// feeding a slave latch open on clk=1, both cleared by the active-low reset.
module flipflop_d
  import flipflop_d_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire             clk,
  input  wire             reset,
  input  wire [WIDTH-1:0] d,
  output wire [WIDTH-1:0] q,
  output wire [WIDTH-1:0] qbar
);
  wire clkn;

  not g_clkn (clkn, clk);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      wire dn, mq, mqb;

      not g_dn (dn, d[i]);

      d_latch u_master (
        .en    (clkn),
        .clr_n (reset),
        .d     (d[i]),
        .dn    (dn),
        .q     (mq),
        .qbar  (mqb)
      );

      // Master's complementary outputs serve directly as the slave's data rails.
      d_latch u_slave (
        .en    (clk),
        .clr_n (reset),
        .d     (mq),
        .dn    (mqb),
        .q     (q[i]),
        .qbar  (qbar[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_flipflop_d.sv
// Directed plus randomized bench for flipflop_d (WIDTH=4) against an edge-level model.
module tb_flipflop_d;
  localparam int W = 4;

  logic clk;
  logic reset;
  logic [W-1:0] m_q;
  int total;
  int fails;

  flipflop_d_if #(.WIDTH(W)) bus ();

  flipflop_d #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .d     (bus.d),
    .q     (bus.q),
    .qbar  (bus.qbar)
  );

  task automatic chk(input string tag);
    total++;
    assert (bus.q === m_q) else begin
      fails++;
      $error("FAIL %s q=%b expected %b", tag, bus.q, m_q);
    end
    total++;
    assert (bus.qbar === ~m_q) else begin
      fails++;
      $error("FAIL %s qbar=%b expected %b", tag, bus.qbar, ~m_q);
    end
  endtask

  // Model: reset low clears; otherwise q only follows d at a rising clock edge.
  task automatic set_reset(input logic v);
    reset = v;
    if (!v) m_q = '0;
    #10;
  endtask

  task automatic clk_up();
    clk = 1'b1;
    if (reset) m_q = bus.d;
    #10;
  endtask

  task automatic clk_dn();
    clk = 1'b0;
    #10;
  endtask

  task automatic set_d(input logic [W-1:0] v);
    bus.d = v;
    #10;
  endtask

  initial begin
    total = 0;
    fails = 0;
    m_q   = '0;
    clk   = 1'b0;
    reset = 1'b0;
    bus.d = '0;
    #10;
    chk("reset_idle");

    // Clock and data activity under reset
    set_d('1);          chk("rst_d1");
    clk_up();           chk("rst_rise");
    set_d('0);          chk("rst_d0_clkhi");
    clk_dn();           chk("rst_fall");
    clk_up();           chk("rst_rise2");

    // Release does not capture; first capture at the next rising edge
    set_d('1);
    set_reset(1'b1);    chk("release_no_capture");
    clk_dn();           chk("release_fall");
    clk_up();           chk("capture_ones");
    set_d('0);          chk("hold_clk_hi");
    clk_dn();           chk("hold_clk_fall");
    clk_up();           chk("capture_zeros");

    // Asynchronous reset with clock held high, then release
    set_d('1);
    clk_dn();
    clk_up();           chk("q_set_before_rst");
    set_reset(1'b0);    chk("async_rst_clk_hi");
    set_d('1);
    set_reset(1'b1);    chk("no_stale_master");
    clk_dn();           chk("post_rel_fall");
    clk_up();           chk("post_rel_capture");

    // Asynchronous reset with clock low, and an edge while held in reset
    clk_dn();
    set_reset(1'b0);    chk("async_rst_clk_lo");
    clk_up();           chk("edge_in_rst");
    set_reset(1'b1);

    // Per-bit independence
    set_d(4'b1010);
    clk_dn();
    clk_up();           chk("cap_1010");
    set_d(4'b0110);     chk("no_edge_0110");
    clk_dn();           chk("fall_0110");
    clk_up();           chk("cap_0110");

    // Randomized sequences with occasional reset pulses
    for (int n = 0; n < 60; n++) begin
      clk_dn();
      set_d(W'($urandom));
      chk("rnd_lo");
      if ($urandom_range(0, 7) == 0) begin
        set_reset(1'b0);
        chk("rnd_rst");
        if ($urandom_range(0, 1) == 1) begin
          clk_up();
          chk("rnd_edge_in_rst");
          clk_dn();
        end
        set_d(W'($urandom));
        set_reset(1'b1);
        chk("rnd_release");
      end
      clk_up();
      chk("rnd_capture");
      set_d(W'($urandom));
      chk("rnd_hold");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
